rmt_input_arbiter: RTL and testbench

Two-port packet-granular round-robin AXI4-Stream arbiter placed directly upstream of the RMT pipeline's slave stream input. It merges two 256-bit ingress streams (e.g. two MAC ports) into the single stream consumed by the packet filter and parser. Packets are never interleaved, and the output is registered. It also keeps per-port accepted-packet counters for debug.

---
 rtl/rmt_input_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rmt_input_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_input_arbiter.sv
// Two-port packet-granular round-robin AXI4-Stream arbiter in front of the
// RMT pipeline; registered output, per-port accepted-packet counters.
module rmt_input_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [31:0]                       pkt_cnt0,
    output logic [31:0]                       pkt_cnt1
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [DW-1:0]   m_tdata_q, m_tdata_d;
    logic [KW-1:0]   m_tkeep_q, m_tkeep_d;
    logic [UW-1:0]   m_tuser_q, m_tuser_d;
    logic            m_tlast_q, m_tlast_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic [31:0]     pkt_cnt0_q, pkt_cnt0_d;
    logic [31:0]     pkt_cnt1_q, pkt_cnt1_d;

    logic            gnt_vld;
    logic            gnt_port;
    logic            pref_vld;
    logic            other_vld;
    logic            slot_free;
    logic            acc0;
    logic            acc1;
    logic            acc_last;

    // The port that did not finish the previous packet is preferred in IDLE.
    assign pref_vld  = last_q ? s0_axis_tvalid : s1_axis_tvalid;
    assign other_vld = last_q ? s1_axis_tvalid : s0_axis_tvalid;

    // State register plus pointer, output register and counters.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tuser_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tuser_q  <= m_tuser_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    // Grant: owner port mid-packet, otherwise round-robin among valid ports.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        unique case (state_q)
            PKT0: begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b0;
            end
            PKT1: begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b1;
            end
            default: begin
                if (pref_vld) begin
                    gnt_vld  = 1'b1;
                    gnt_port = ~last_q;
                end else if (other_vld) begin
                    gnt_vld  = 1'b1;
                    gnt_port = last_q;
                end
            end
        endcase
    end

    assign slot_free      = !m_tvalid_q || m_axis_tready;
    assign s0_axis_tready = gnt_vld && !gnt_port && slot_free;
    assign s1_axis_tready = gnt_vld && gnt_port && slot_free;
    assign acc0           = s0_axis_tvalid && s0_axis_tready;
    assign acc1           = s1_axis_tvalid && s1_axis_tready;
    assign acc_last       = acc0 ? s0_axis_tlast : s1_axis_tlast;

    // Next state: a tlast accept always returns to IDLE and moves the pointer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (acc0 || acc1) begin
            if (acc_last) begin
                state_d = IDLE;
                last_d  = acc1;
            end else begin
                state_d = acc1 ? PKT1 : PKT0;
            end
        end
    end

    // Output register load/hold/drain and per-port packet counters.
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (acc0) begin
            m_tdata_d  = s0_axis_tdata;
            m_tkeep_d  = s0_axis_tkeep;
            m_tuser_d  = s0_axis_tuser;
            m_tlast_d  = s0_axis_tlast;
            m_tvalid_d = 1'b1;
        end else if (acc1) begin
            m_tdata_d  = s1_axis_tdata;
            m_tkeep_d  = s1_axis_tkeep;
            m_tuser_d  = s1_axis_tuser;
            m_tlast_d  = s1_axis_tlast;
            m_tvalid_d = 1'b1;
        end else if (slot_free) begin
            m_tvalid_d = 1'b0;
        end
        pkt_cnt0_d = pkt_cnt0_q + 32'(acc0 && s0_axis_tlast);
        pkt_cnt1_d = pkt_cnt1_q + 32'(acc1 && s1_axis_tlast);
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign pkt_cnt0      = pkt_cnt0_q;
    assign pkt_cnt1      = pkt_cnt1_q;

endmodule

// File: tb/tb_rmt_input_arbiter.sv
// Self-checking bench for rmt_input_arbiter: vector table, directed
// corner sequences and a randomized run against a packet-order model.
module tb_rmt_input_arbiter;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [255:0] s0_tdata, s1_tdata, m_tdata;
    logic [31:0]  s0_tkeep, s1_tkeep, m_tkeep;
    logic [127:0] s0_tuser, s1_tuser, m_tuser;
    logic         s0_tvalid, s1_tvalid, m_tvalid;
    logic         s0_tlast, s1_tlast, m_tlast;
    logic         s0_tready, s1_tready, m_tready;
    logic [31:0]  pkt_cnt0, pkt_cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    typedef struct {
        bit v0, v1, l0, l1, mr;
        bit r0, r1, mv, ml;
        logic [15:0] ed;
    } vec_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    rmt_input_arbiter dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tkeep  (s0_tkeep),
        .s0_axis_tuser  (s0_tuser),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tkeep  (s1_tkeep),
        .s1_axis_tuser  (s1_tuser),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tuser   (m_tuser),
        .m_axis_tlast   (m_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(int port, int pkt, int bt, bit last);
        beat_t b;
        b.d          = '0;
        b.d[3:0]     = 4'(bt);
        b.d[7:4]     = 4'(port);
        b.d[23:8]    = 16'(pkt);
        b.d[255:240] = 16'hBEEF ^ 16'(pkt * 3 + bt);
        b.k          = 32'(pkt * 7 + bt + port * 1000);
        b.u          = {96'h0, b.d[31:0] ^ 32'h5A5A_5A5A};
        b.l          = last;
        return b;
    endfunction

    function automatic beat_t raw_beat(logic [255:0] d, bit last);
        beat_t b;
        b.d = d;
        b.k = d[31:0] ^ 32'hFFFF_0000;
        b.u = {d[127:0]};
        b.l = last;
        return b;
    endfunction

    task automatic drive(input int p, input bit v, input beat_t b);
        if (p == 0) begin
            s0_tvalid = v;
            s0_tdata  = b.d;
            s0_tkeep  = b.k;
            s0_tuser  = b.u;
            s0_tlast  = b.l;
        end else begin
            s1_tvalid = v;
            s1_tdata  = b.d;
            s1_tkeep  = b.k;
            s1_tuser  = b.u;
            s1_tlast  = b.l;
        end
    endtask

    task automatic idle_inputs();
        beat_t z;
        z = raw_beat('0, 1'b0);
        drive(0, 1'b0, z);
        drive(1, 1'b0, z);
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn  = 1'b0;
        m_tready = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic chk_out(input string nm, input beat_t b);
        chk(nm, {m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata},
            {1'b1, b.l, b.u, b.k, b.d});
    endtask

    task automatic run_stream(input int n0, input int n1, input int lmin,
                              input int lmax, input int gap_pct,
                              input int rdy_pct, input bit nogap);
        int    len0[$], len1[$];
        int    pi0, bi0, pi1, bi1, i, j;
        bit    v0, v1, a0, a1, turn, done, hold, started;
        beat_t b0, b1, saved, e;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < n0; k++) len0.push_back($urandom_range(lmax, lmin));
        for (int k = 0; k < n1; k++) len1.push_back($urandom_range(lmax, lmin));
        i = 0;
        j = 0;
        turn = 1'b0;
        while (i < n0 || j < n1) begin
            if (i < n0 && (turn == 1'b0 || j >= n1)) begin
                for (int b = 0; b < len0[i]; b++)
                    exp_q.push_back(mk_beat(0, i, b, b == len0[i] - 1));
                i++;
                turn = 1'b1;
            end else begin
                for (int b = 0; b < len1[j]; b++)
                    exp_q.push_back(mk_beat(1, j, b, b == len1[j] - 1));
                j++;
                turn = 1'b0;
            end
        end
        pi0 = 0; bi0 = 0; pi1 = 0; bi1 = 0;
        v0 = 0; v1 = 0; done = 0; started = 0;
        b0 = raw_beat('0, 0);
        b1 = raw_beat('0, 0);
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (!v0 && pi0 < n0)
                v0 = (bi0 == 0) || ($urandom_range(99) >= gap_pct);
            if (!v1 && pi1 < n1)
                v1 = (bi1 == 0) || ($urandom_range(99) >= gap_pct);
            if (pi0 < n0) b0 = mk_beat(0, pi0, bi0, bi0 == len0[pi0] - 1);
            if (pi1 < n1) b1 = mk_beat(1, pi1, bi1, bi1 == len1[pi1] - 1);
            drive(0, v0, b0);
            drive(1, v1, b1);
            m_tready = ($urandom_range(99) < rdy_pct);
            #1;
            a0 = s0_tvalid && s0_tready;
            a1 = s1_tvalid && s1_tready;
            chk("one_grant", s0_tready & s1_tready, 1'b0);
            if (nogap && started && exp_q.size() > 0)
                chk("no_gap", m_tvalid, 1'b1);
            if (m_tvalid && m_tready) begin
                started = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk_out("stream_beat", e);
                end
            end
            hold = m_tvalid && !m_tready;
            saved.d = m_tdata;
            saved.k = m_tkeep;
            saved.u = m_tuser;
            saved.l = m_tlast;
            @(posedge clk);
            #1;
            if (hold) chk_out("stall_stable", saved);
            if (a0) begin
                bi0++;
                v0 = 0;
                if (bi0 == len0[pi0]) begin
                    pi0++;
                    bi0 = 0;
                end
            end
            if (a1) begin
                bi1++;
                v1 = 0;
                if (bi1 == len1[pi1]) begin
                    pi1++;
                    bi1 = 0;
                end
            end
            done = (exp_q.size() == 0) && pi0 == n0 && pi1 == n1;
        end
        chk("stream_timeout", done, 1'b1);
        chk("stream_cnt0", pkt_cnt0, 32'(n0));
        chk("stream_cnt1", pkt_cnt1, 32'(n1));
        idle_inputs();
    endtask

    vec_t  vt[11];
    beat_t bb, c0, c1;

    initial begin
        aresetn = 1'b0;
        m_tready = 1'b0;
        idle_inputs();

        do_reset();
        chk("rst_mvalid", m_tvalid, 1'b0);
        chk("rst_mout", {m_tlast, m_tuser, m_tkeep, m_tdata}, '0);
        chk("rst_cnts", {pkt_cnt0, pkt_cnt1}, 64'h0);

        // Single-cycle vectors: v0 v1 l0 l1 mr | r0 r1 mv ml data
        vt[0]  = '{1,1,1,1,1, 1,0,1,1, 16'h100};
        vt[1]  = '{1,1,1,1,1, 0,1,1,1, 16'h201};
        vt[2]  = '{1,0,1,0,0, 0,0,1,1, 16'h201};
        vt[3]  = '{0,1,0,1,1, 0,1,1,1, 16'h203};
        vt[4]  = '{0,0,0,0,1, 0,0,0,0, 16'h000};
        vt[5]  = '{1,1,0,1,1, 1,0,1,0, 16'h105};
        vt[6]  = '{1,1,0,1,0, 0,0,1,0, 16'h105};
        vt[7]  = '{1,1,1,1,1, 1,0,1,1, 16'h107};
        vt[8]  = '{0,1,0,1,1, 0,1,1,1, 16'h208};
        vt[9]  = '{0,0,0,0,0, 0,0,1,1, 16'h208};
        vt[10] = '{0,0,0,0,1, 0,0,0,0, 16'h000};
        for (int r = 0; r < 11; r++) begin
            @(negedge clk);
            drive(0, vt[r].v0, raw_beat(256'(16'h100 + r), vt[r].l0));
            drive(1, vt[r].v1, raw_beat(256'(16'h200 + r), vt[r].l1));
            m_tready = vt[r].mr;
            #1;
            chk($sformatf("vec%0d_ready", r), {s0_tready, s1_tready},
                {vt[r].r0, vt[r].r1});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_mvalid", r), m_tvalid, vt[r].mv);
            if (vt[r].mv)
                chk($sformatf("vec%0d_mdata", r), {m_tlast, m_tdata},
                    {vt[r].ml, 256'(vt[r].ed)});
        end
        chk("vec_cnts", {pkt_cnt0, pkt_cnt1}, {32'd2, 32'd3});

        // Single port, 3-beat packet.
        do_reset();
        m_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bb = raw_beat(256'(8'hA1 + b), b == 2);
            drive(0, 1'b1, bb);
            @(posedge clk);
            #1;
            chk($sformatf("single_beat%0d", b), {m_tvalid, m_tlast, m_tdata},
                {1'b1, bb.l, bb.d});
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("single_drain", m_tvalid, 1'b0);
        chk("single_cnts", {pkt_cnt0, pkt_cnt1}, {32'd1, 32'd0});

        // No mid-packet preemption: port 1 arrives during beat 2 of 5.
        do_reset();
        m_tready = 1'b1;
        c1 = mk_beat(1, 9, 0, 1'b1);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            c0 = mk_beat(0, 3, b, b == 4);
            drive(0, 1'b1, c0);
            if (b >= 1) drive(1, 1'b1, c1);
            #1;
            chk($sformatf("nopre_r%0d", b), {s0_tready, s1_tready}, 2'b10);
            @(posedge clk);
            #1;
            chk_out($sformatf("nopre_out%0d", b), c0);
        end
        @(negedge clk);
        drive(0, 1'b0, c0);
        #1;
        chk("nopre_p1_ready", s1_tready, 1'b1);
        @(posedge clk);
        #1;
        chk_out("nopre_p1_out", c1);
        chk("nopre_cnts", {pkt_cnt0, pkt_cnt1}, {32'd1, 32'd1});
        idle_inputs();

        // Contention with 4-beat packets, then single-beat alternation.
        run_stream(2, 2, 4, 4, 0, 100, 1'b1);
        run_stream(6, 6, 1, 1, 0, 100, 1'b1);
        // Random gaps and 50% backpressure over 100 packets.
        run_stream(50, 50, 1, 6, 25, 50, 1'b0);

        // Counter wrap.
        do_reset();
        m_tready = 1'b1;
        @(negedge clk);
        force dut.pkt_cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt0_q;
        drive(0, 1'b1, mk_beat(0, 0, 0, 1'b1));
        @(posedge clk);
        #1;
        chk("wrap_cnt0", pkt_cnt0, 32'h0);
        chk("wrap_cnt1", pkt_cnt1, 32'h0);

        // Reset mid-packet, then tie must go to port 0.
        @(negedge clk);
        drive(0, 1'b1, mk_beat(0, 1, 0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        aresetn = 1'b0;
        drive(0, 1'b1, mk_beat(0, 1, 1, 1'b1));
        drive(1, 1'b1, mk_beat(1, 1, 0, 1'b1));
        @(posedge clk);
        #1;
        chk("midrst_mvalid", m_tvalid, 1'b0);
        chk("midrst_mout", {m_tlast, m_tuser, m_tkeep, m_tdata}, '0);
        chk("midrst_cnts", {pkt_cnt0, pkt_cnt1}, 64'h0);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        chk("midrst_tie", {s0_tready, s1_tready}, 2'b10);
        @(posedge clk);
        #1;
        chk_out("midrst_first", mk_beat(0, 1, 1, 1'b1));
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
